im_loader: RTL and testbench
============================

Name: im_loader

Overview:
Boot-time program loader that sits directly upstream of the core's instruction memory and the core's start input.
- Accepts a byte stream over a valid/ready handshake.
- Packs byte pairs into IW-bit instruction words and writes them through a registered write port into instruction memory.
- Raises start to release the core once the last word has been written.
- The core stays halted (start low) until loading completes.

Parameters:
IW, 12, instruction width in bits; legal range 9..16 (two bytes per word)
IMW, 4, instruction memory address width; depth = 2^IMW words

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
in_data  in  8  stream byte
in_valid  in  1  in_data valid
in_ready  out  1  loader can accept a byte this cycle
im_we  out  1  instruction memory write enable (one-cycle pulse)
im_waddr  out  IMW  instruction memory write address
im_wdata  out  IW  instruction memory write data
start  out  1  core run enable, level
busy  out  1  high while a load is in progress (any state except IDLE, RUN, ERR)
err  out  1  load failed (checksum build only)
words_loaded  out  IMW+1  count of words written so far

Behaviour:
- Reset (async, rst=1): state=IDLE; im_we=0, im_waddr=0, im_wdata=0, start=0, busy=0, err=0, words_loaded=0. in_ready follows state (1 in IDLE).
- Transfer occurs on a rising edge where in_valid && in_ready. in_ready is 1 in IDLE, LO, HI and CHK; 0 in WAIT, RUN and ERR. in_ready is a function of state only, never of in_valid.
- IDLE: the first accepted byte is the length L.
  - Target count N = 2^IMW if L==0 or L>2^IMW, else N = L.
  - Clear the word index.
  - Go to LO.
- LO: accepted byte latched as word bits [7:0]; go to HI.
- HI: accepted byte bits [IW-9:0] become word bits [IW-1:8]; excess high bits are ignored.
  - On the following cycle: im_we=1, im_waddr=index, im_wdata=packed word. This gives a write latency of 1 cycle after HI acceptance.
  - words_loaded increments in the same cycle im_we is high.
  - If index+1 < N, index increments and the state goes to LO.
  - Otherwise the state goes to WAIT (non-checksum build) or CHK (checksum build).
- WAIT: one cycle, so that the final im_we pulse has completed; then go to RUN.
- RUN: start=1 and held until rst. All further stream bytes are back-pressured (in_ready=0).
- Writes never exceed address 2^IMW-1; the index does not wrap within a load.
- im_we is high for exactly one cycle per word and never high in IDLE, RUN or ERR.
- A gap in in_valid in any accepting state holds the state; no timeout.
- rst asserted mid-load: immediate return to IDLE.
  - Partially written memory contents are left as-is.
  - start is dropped, so the core halts.
  - A new load overwrites memory from address 0.

Optional Feature:
IM_LOADER_CHECKSUM_EN
- Defined:
  - After the last HI byte, go to CHK and accept one checksum byte.
  - Compare it with the XOR of all payload bytes, excluding the length byte.
  - Match: go to WAIT, then RUN.
  - Mismatch: go to ERR, where err=1, start=0 and in_ready=0 until rst.
- Undefined:
  - No CHK or ERR states exist.
  - err is tied 0.
  - The stream carries no checksum byte.

Test Plan:
- Reset values: assert rst asynchronously between edges -> all outputs go to reset values immediately; in_ready=1; start=0.
- Three-word load: stream 03, 34,12, 78,F6, BC,FA back-to-back.
  - im_we pulses with (addr,data) = (0,0x234), (1,0x678), (2,0xABC).
  - words_loaded ends at 3.
  - start rises 2 cycles after the last im_we (WAIT, then RUN) and stays high; in_ready=0 thereafter.
- Full/clamp: L=0x00 and separately L=0xFF with IMW=4.
  - Exactly 16 writes, addresses 0..15.
  - The extra byte offered after word 15 is not accepted; start=1.
- Backpressure gaps: the same three-word load with in_valid toggling 1/0 every cycle -> identical writes and data; no duplicate im_we.
- Reset mid-load: pulse rst after the 2nd word is written, then load 01, 11,01.
  - start drops during rst.
  - The single write (0,0x111) occurs; words_loaded=1; start=1.
- Checksum (IM_LOADER_CHECKSUM_EN):
  - 01, 34,12, then 26 -> start=1, err=0.
  - Repeating the same load with final byte 00 -> err=1, start=0, in_ready=0.

Source files
------------

// File: rtl/im_loader.sv
// Boot-time program loader: packs a length-prefixed byte stream into IW-bit words, writes them to
// instruction memory, then releases the core. Optional checksum build: define IM_LOADER_CHECKSUM_EN.
module im_loader #(
   parameter int IW  = 12,
   parameter int IMW = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [7:0]     in_data,
   input  logic           in_valid,
   output logic           in_ready,
   output logic           im_we,
   output logic [IMW-1:0] im_waddr,
   output logic [IW-1:0]  im_wdata,
   output logic           start,
   output logic           busy,
   output logic           err,
   output logic [IMW:0]   words_loaded
);

   localparam int unsigned DEPTH = 2 ** IMW;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LO,
      S_HI,
      S_WAIT,
      S_RUN
`ifdef IM_LOADER_CHECKSUM_EN
      , S_CHK,
      S_ERR
`endif
   } state_t;

   state_t         state, next_state;
   logic [IMW-1:0] idx;
   logic [IMW:0]   target;
   logic [7:0]     lo_byte;
   logic           xfer;
   logic           last;
`ifdef IM_LOADER_CHECKSUM_EN
   logic [7:0]     csum;
`endif

   // A length of zero or beyond the memory depth loads the whole memory.
   function automatic logic [IMW:0] clamp_len(input logic [7:0] l);
      int unsigned v;
      v = 32'(l);
      if (v == 0 || v > DEPTH) v = DEPTH;
      return v[IMW:0];
   endfunction

   assign xfer = in_valid & in_ready;
   assign last = ({1'b0, idx} + (IMW+1)'(1)) >= target;

`ifdef IM_LOADER_CHECKSUM_EN
   assign err = (state == S_ERR);
`else
   assign err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      busy       = 1'b0;
      case (state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) next_state = S_LO;
         end
         S_LO: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (in_valid) next_state = S_HI;
         end
         S_HI: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (in_valid) begin
`ifdef IM_LOADER_CHECKSUM_EN
               next_state = last ? S_CHK : S_LO;
`else
               next_state = last ? S_WAIT : S_LO;
`endif
            end
         end
         S_WAIT: begin
            busy       = 1'b1;
            next_state = S_RUN;
         end
`ifdef IM_LOADER_CHECKSUM_EN
         S_CHK: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (in_valid) next_state = (in_data == csum) ? S_WAIT : S_ERR;
         end
         S_ERR: ;
`endif
         S_RUN: ;
         default: next_state = S_IDLE;
      endcase
   end

   // start is registered from the RUN state, so it rises two cycles after the final write pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx          <= '0;
         target       <= '0;
         lo_byte      <= '0;
         im_we        <= 1'b0;
         im_waddr     <= '0;
         im_wdata     <= '0;
         words_loaded <= '0;
         start        <= 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
         csum         <= '0;
`endif
      end else begin
         im_we <= 1'b0;
         start <= (state == S_RUN);
         if (xfer) begin
            case (state)
               S_IDLE: begin
                  target       <= clamp_len(in_data);
                  idx          <= '0;
                  words_loaded <= '0;
`ifdef IM_LOADER_CHECKSUM_EN
                  csum         <= '0;
`endif
               end
               S_LO: begin
                  lo_byte <= in_data;
`ifdef IM_LOADER_CHECKSUM_EN
                  csum    <= csum ^ in_data;
`endif
               end
               S_HI: begin
                  im_we        <= 1'b1;
                  im_waddr     <= idx;
                  im_wdata     <= {in_data[IW-9:0], lo_byte};
                  words_loaded <= words_loaded + (IMW+1)'(1);
                  if (!last) idx <= idx + IMW'(1);
`ifdef IM_LOADER_CHECKSUM_EN
                  csum         <= csum ^ in_data;
`endif
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_im_loader.sv
// Directed self-checking bench for im_loader (IW=12, IMW=4); checksum cases run when
// IM_LOADER_CHECKSUM_EN is defined.
module tb_im_loader;

   localparam int IW  = 12;
   localparam int IMW = 4;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [7:0]     in_data = '0;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic           im_we;
   logic [IMW-1:0] im_waddr;
   logic [IW-1:0]  im_wdata;
   logic           start;
   logic           busy;
   logic           err;
   logic [IMW:0]   words_loaded;

   im_loader #(.IW(IW), .IMW(IMW)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .im_we        (im_we),
      .im_waddr     (im_waddr),
      .im_wdata     (im_wdata),
      .start        (start),
      .busy         (busy),
      .err          (err),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int last_we_cyc = -1;
   int start_rise_cyc = -1;
   int we_with_start = 0;
   logic start_prev = 1'b0;

   logic [IMW-1:0] wr_addr[$];
   logic [IW-1:0]  wr_data[$];
   logic [IMW-1:0] exp_addr[$];
   logic [IW-1:0]  exp_data[$];
   logic [7:0]     byte_q[$];

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (im_we) begin
         wr_addr.push_back(im_waddr);
         wr_data.push_back(im_wdata);
         last_we_cyc = cyc;
         if (start) we_with_start++;
      end
      if (start && !start_prev) start_rise_cyc = cyc;
      start_prev = start;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clear_mon();
      wr_addr.delete();
      wr_data.delete();
      we_with_start  = 0;
      start_rise_cyc = -1;
      last_we_cyc    = -1;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_we"},    im_we, 0);
      check({tag, "_addr"},  im_waddr, 0);
      check({tag, "_data"},  im_wdata, 0);
      check({tag, "_start"}, start, 0);
      check({tag, "_busy"},  busy, 0);
      check({tag, "_err"},   err, 0);
      check({tag, "_words"}, words_loaded, 0);
      check({tag, "_ready"}, in_ready, 1);
   endtask

   // Reset is raised between clock edges and the outputs are checked before any edge arrives.
   task automatic do_reset(input string tag, input bit chk_vals);
      @(negedge clk);
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      if (chk_vals) check_reset_vals(tag);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
      clear_mon();
   endtask

   task automatic send(input logic [7:0] b);
      bit got = 1'b0;
      in_data  = b;
      in_valid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (in_ready) begin
            got = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      if (!got) check("accept_timeout", 0, 1);
   endtask

   task automatic load(input bit gap);
      logic [7:0] x = '0;
      for (int i = 0; i < byte_q.size(); i++) begin
         send(byte_q[i]);
         if (i > 0) x = x ^ byte_q[i];
         if (gap) begin
            @(posedge clk);
            #1;
         end
      end
`ifdef IM_LOADER_CHECKSUM_EN
      send(x);
`endif
   endtask

   task automatic wait_start();
      bit seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (start) begin
            seen = 1'b1;
            break;
         end
      end
      check("start_timeout", seen, 1);
      repeat (2) @(negedge clk);
   endtask

   task automatic check_writes(input string tag);
      check({tag, "_wr_count"}, wr_data.size(), exp_data.size());
      for (int i = 0; i < exp_data.size() && i < wr_data.size(); i++) begin
         check($sformatf("%s_addr%0d", tag, i), wr_addr[i], exp_addr[i]);
         check($sformatf("%s_data%0d", tag, i), wr_data[i], exp_data[i]);
      end
   endtask

   task automatic full_load(input logic [7:0] len, input string tag);
      logic [7:0] lo_v;
      logic [7:0] hi_v;
      int n_before;
      byte_q = {len};
      exp_addr.delete();
      exp_data.delete();
      for (int i = 0; i < 16; i++) begin
         lo_v = 8'(i * 7 + 3);
         hi_v = 8'(8'hC0 + i);
         byte_q.push_back(lo_v);
         byte_q.push_back(hi_v);
         exp_addr.push_back(IMW'(i));
         exp_data.push_back({hi_v[3:0], lo_v});
      end
      load(1'b0);
      wait_start();
      check_writes(tag);
      check({tag, "_words"}, words_loaded, 16);
      n_before = wr_data.size();
      in_data  = 8'h55;
      in_valid = 1'b1;
      repeat (4) @(negedge clk);
      check({tag, "_extra_ready"}, in_ready, 0);
      check({tag, "_extra_nowr"}, wr_data.size(), n_before);
      check({tag, "_start"}, start, 1);
      in_valid = 1'b0;
   endtask

   initial begin
      clear_mon();
      #1;
      check_reset_vals("por");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;

      send(8'h01);
      send(8'h34);
      @(negedge clk);
      check("mid_busy", busy, 1);
      do_reset("async_mid", 1'b1);

      byte_q   = {8'h03, 8'h34, 8'h12, 8'h78, 8'hF6, 8'hBC, 8'hFA};
      exp_addr = {4'd0, 4'd1, 4'd2};
      exp_data = {12'h234, 12'h678, 12'hABC};
      load(1'b0);
      wait_start();
      check_writes("three");
      check("three_words", words_loaded, 3);
      check("three_ready", in_ready, 0);
      check("three_busy", busy, 0);
      check("three_err", err, 0);
      check("three_we_start", we_with_start, 0);
`ifndef IM_LOADER_CHECKSUM_EN
      check("three_start_lat", start_rise_cyc - last_we_cyc, 2);
`endif
      do_reset("rst_run", 1'b1);

      full_load(8'h00, "len00");
      do_reset("rst_len00", 1'b0);
      full_load(8'hFF, "lenFF");
      do_reset("rst_lenFF", 1'b0);

      byte_q   = {8'h03, 8'h34, 8'h12, 8'h78, 8'hF6, 8'hBC, 8'hFA};
      exp_addr = {4'd0, 4'd1, 4'd2};
      exp_data = {12'h234, 12'h678, 12'hABC};
      load(1'b1);
      wait_start();
      check_writes("gap");
      check("gap_words", words_loaded, 3);
      check("gap_start", start, 1);
      do_reset("rst_gap", 1'b1);

      send(8'h03);
      send(8'h34);
      send(8'h12);
      send(8'h78);
      send(8'hF6);
      repeat (2) @(negedge clk);
      check("part_words", words_loaded, 2);
      check("part_wr_count", wr_data.size(), 2);
      check("part_start", start, 0);
      do_reset("rst_part", 1'b1);
      byte_q   = {8'h01, 8'h11, 8'h01};
      exp_addr = {4'd0};
      exp_data = {12'h111};
      load(1'b0);
      wait_start();
      check_writes("reload");
      check("reload_words", words_loaded, 1);
      check("reload_start", start, 1);

`ifdef IM_LOADER_CHECKSUM_EN
      do_reset("rst_ck", 1'b0);
      send(8'h01);
      send(8'h34);
      send(8'h12);
      send(8'h26);
      wait_start();
      check("ck_ok_start", start, 1);
      check("ck_ok_err", err, 0);
      do_reset("rst_ck2", 1'b0);
      send(8'h01);
      send(8'h34);
      send(8'h12);
      send(8'h00);
      repeat (5) @(negedge clk);
      check("ck_bad_err", err, 1);
      check("ck_bad_start", start, 0);
      check("ck_bad_ready", in_ready, 0);
      check("ck_bad_busy", busy, 0);
`else
      check("nock_err", err, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
